// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access at a time, stalls the
// upstream pipeline while waiting for ack (with timeout) and loads MEM/WB.
module mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iInstr,
    input  logic        iRegWrite,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iMemToReg,
    input  logic        iBranch,
    input  logic        iJump,
    input  logic [31:0] iB,
    input  logic [31:0] iResult,
    input  logic        iZero,
    input  logic [31:0] inextPCBranch,
    input  logic [4:0]  iwriteRegWire,
    output logic        oStall,
    output logic        oPCSrc,
    output logic [31:0] oBranchTarget,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] oInstr,
    output logic        oRegWrite,
    output logic        oMemToReg,
    output logic [31:0] oReadData,
    output logic [31:0] oResult,
    output logic [4:0]  owriteRegWire,
    output logic        oValid,
    output logic        oAddrErr,
    output logic        oMemErr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        WB_BUBBLE = 2'd0,
        WB_PASS   = 2'd1,
        WB_MEM    = 2'd2
    } wb_sel_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    wb_sel_t     w_wb_sel;

    logic        w_access;
    logic        w_aligned;
    logic        w_capture;
    logic        w_addr_err;
    logic        w_mem_err;
    logic        w_stall;
    logic        w_unused;

    // Access latched at issue; drives the memory port for the whole WAIT.
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_instr;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic [4:0]  r_wreg;

    logic [31:0] r_o_instr;
    logic        r_o_regwrite;
    logic        r_o_memtoreg;
    logic [31:0] r_o_readdata;
    logic [31:0] r_o_result;
    logic [4:0]  r_o_wreg;
    logic        r_o_valid;
    logic        r_o_addr_err;
    logic        r_o_mem_err;

    assign w_access  = iMemRead | iMemWrite;
    assign w_aligned = (iResult[1:0] == 2'b00);
    assign w_unused  = iJump;

    // Next-state, wait counter and write-back selection.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wb_sel     = WB_BUBBLE;
        w_capture    = 1'b0;
        w_addr_err   = 1'b0;
        w_mem_err    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_aligned) begin
                        w_capture    = 1'b1;
                        w_stall      = 1'b1;
                        w_cnt_next   = 4'd0;
                        w_state_next = S_WAIT;
                    end else begin
                        w_addr_err   = 1'b1;
                    end
                end else begin
                    w_wb_sel = WB_PASS;
                end
            end
            S_WAIT: begin
                // Ack takes priority over timeout, even on the last count.
                if (dmem_ack) begin
                    w_wb_sel     = WB_MEM;
                    w_cnt_next   = 4'd0;
                    w_state_next = S_IDLE;
                end else if (r_cnt == 4'd15) begin
                    w_mem_err    = 1'b1;
                    w_cnt_next   = 4'd0;
                    w_state_next = S_IDLE;
                end else begin
                    w_stall      = 1'b1;
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            default: begin
                w_cnt_next   = 4'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the access and its pass-through fields at issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_instr    <= 32'd0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_wreg     <= 5'd0;
        end else if (w_capture) begin
            r_we       <= iMemWrite;
            r_addr     <= iResult;
            r_wdata    <= iB;
            r_instr    <= iInstr;
            r_regwrite <= iRegWrite;
            r_memtoreg <= iMemToReg;
            r_wreg     <= iwriteRegWire;
        end else begin
            r_we       <= r_we;
            r_addr     <= r_addr;
            r_wdata    <= r_wdata;
            r_instr    <= r_instr;
            r_regwrite <= r_regwrite;
            r_memtoreg <= r_memtoreg;
            r_wreg     <= r_wreg;
        end
    end

    // MEM/WB register and error pulses; a bubble keeps the data fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_o_instr    <= 32'd0;
            r_o_regwrite <= 1'b0;
            r_o_memtoreg <= 1'b0;
            r_o_readdata <= 32'd0;
            r_o_result   <= 32'd0;
            r_o_wreg     <= 5'd0;
            r_o_valid    <= 1'b0;
            r_o_addr_err <= 1'b0;
            r_o_mem_err  <= 1'b0;
        end else begin
            r_o_addr_err <= w_addr_err;
            r_o_mem_err  <= w_mem_err;
            case (w_wb_sel)
                WB_PASS: begin
                    r_o_instr    <= iInstr;
                    r_o_regwrite <= iRegWrite;
                    r_o_memtoreg <= iMemToReg;
                    r_o_readdata <= 32'd0;
                    r_o_result   <= iResult;
                    r_o_wreg     <= iwriteRegWire;
                    r_o_valid    <= ~((iInstr == 32'd0) && !iRegWrite);
                end
                WB_MEM: begin
                    r_o_instr    <= r_instr;
                    r_o_regwrite <= r_regwrite;
                    r_o_memtoreg <= r_memtoreg;
                    r_o_readdata <= r_we ? 32'd0 : dmem_rdata;
                    r_o_result   <= r_addr;
                    r_o_wreg     <= r_wreg;
                    r_o_valid    <= 1'b1;
                end
                default: begin
                    r_o_instr    <= r_o_instr;
                    r_o_regwrite <= 1'b0;
                    r_o_memtoreg <= 1'b0;
                    r_o_readdata <= r_o_readdata;
                    r_o_result   <= r_o_result;
                    r_o_wreg     <= 5'd0;
                    r_o_valid    <= 1'b0;
                end
            endcase
        end
    end

    assign oStall        = w_stall;
    assign oPCSrc        = iBranch & iZero & ~w_stall;
    assign oBranchTarget = inextPCBranch;

    assign dmem_req      = (r_state == S_WAIT);
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;

    assign oInstr        = r_o_instr;
    assign oRegWrite     = r_o_regwrite;
    assign oMemToReg     = r_o_memtoreg;
    assign oReadData     = r_o_readdata;
    assign oResult       = r_o_result;
    assign owriteRegWire = r_o_wreg;
    assign oValid        = r_o_valid;
    assign oAddrErr      = r_o_addr_err;
    assign oMemErr       = r_o_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1 time unit after each rising
// edge, registered outputs are checked there, combinational ones 1 unit later.
module tb_mem_stage;

    localparam logic [31:0] I_LW  = 32'h0040_2283;
    localparam logic [31:0] I_SW  = 32'h00B0_2223;
    localparam logic [31:0] I_ADD = 32'h0073_0333;
    localparam logic [31:0] I_BEQ = 32'h0000_0463;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iInstr;
    logic        iRegWrite, iMemRead, iMemWrite, iMemToReg, iBranch, iJump;
    logic [31:0] iB, iResult, inextPCBranch;
    logic        iZero;
    logic [4:0]  iwriteRegWire;
    logic        oStall, oPCSrc;
    logic [31:0] oBranchTarget;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic [31:0] oInstr;
    logic        oRegWrite, oMemToReg;
    logic [31:0] oReadData, oResult;
    logic [4:0]  owriteRegWire;
    logic        oValid, oAddrErr, oMemErr;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int stall_cnt;
    int req_cnt;

    mem_stage dut (
        .clock(clock), .reset(reset), .iInstr(iInstr), .iRegWrite(iRegWrite),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .iBranch(iBranch), .iJump(iJump), .iB(iB), .iResult(iResult),
        .iZero(iZero), .inextPCBranch(inextPCBranch), .iwriteRegWire(iwriteRegWire),
        .oStall(oStall), .oPCSrc(oPCSrc), .oBranchTarget(oBranchTarget),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .oInstr(oInstr), .oRegWrite(oRegWrite), .oMemToReg(oMemToReg),
        .oReadData(oReadData), .oResult(oResult), .owriteRegWire(owriteRegWire),
        .oValid(oValid), .oAddrErr(oAddrErr), .oMemErr(oMemErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        iInstr = 32'd0; iRegWrite = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
        iMemToReg = 1'b0; iBranch = 1'b0; iJump = 1'b0; iB = 32'd0;
        iResult = 32'd0; iZero = 1'b0; inextPCBranch = 32'd0; iwriteRegWire = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic set_lw(input logic [31:0] addr);
        clr();
        iInstr = I_LW; iMemRead = 1'b1; iRegWrite = 1'b1; iMemToReg = 1'b1;
        iResult = addr; iwriteRegWire = 5'd5;
    endtask

    task automatic set_add(input logic [31:0] res);
        clr();
        iInstr = I_ADD; iRegWrite = 1'b1; iResult = res; iwriteRegWire = 5'd6;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        cyc();
        cyc();
        chk("rst_valid",    32'(oValid), 32'd0);
        chk("rst_req",      32'(dmem_req), 32'd0);
        chk("rst_instr",    oInstr, 32'd0);
        chk("rst_errs",     32'({oAddrErr, oMemErr}), 32'd0);
        chk("rst_stall",    32'(oStall), 32'd0);
        reset = 1'b0;

        // add: one-cycle pass-through
        set_add(32'd7);
        #1;
        chk("add_stall", 32'(oStall), 32'd0);
        cyc();
        chk("add_result", oResult, 32'd7);
        chk("add_valid",  32'(oValid), 32'd1);
        chk("add_rw",     32'(oRegWrite), 32'd1);
        chk("add_wreg",   32'(owriteRegWire), 32'd6);
        chk("add_rdata",  oReadData, 32'd0);
        clr();
        cyc();
        chk("nop_valid",  32'(oValid), 32'd0);

        // lw 0x100, ack three cycles after the request
        stall_cnt = 0;
        set_lw(32'h100);
        #1;
        stall_cnt += int'(oStall);
        chk("lw_req_idle", 32'(dmem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            stall_cnt += int'(oStall);
            chk("lw_req_wait", 32'(dmem_req), 32'd1);
            chk("lw_bubble",   32'(oValid), 32'd0);
        end
        cyc();
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_we",   32'(dmem_we), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        stall_cnt += int'(oStall);
        cyc();
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("lw_rdata", oReadData, 32'hDEAD_BEEF);
        chk("lw_valid", 32'(oValid), 32'd1);
        chk("lw_rw",    32'(oRegWrite), 32'd1);
        chk("lw_m2r",   32'(oMemToReg), 32'd1);
        chk("lw_wreg",  32'(owriteRegWire), 32'd5);
        chk("lw_instr", oInstr, I_LW);
        chk("lw_req_done", 32'(dmem_req), 32'd0);
        clr();
        cyc();
        chk("lw_one_cycle", 32'(oRegWrite), 32'd0);

        // sw 0x204 with read and write both set (write wins), ack after 1 cycle
        clr();
        iInstr = I_SW; iMemWrite = 1'b1; iMemRead = 1'b1;
        iResult = 32'h204; iB = 32'h1234_5678; iwriteRegWire = 5'd3;
        #1;
        chk("sw_stall", 32'(oStall), 32'd1);
        cyc();
        chk("sw_we",    32'(dmem_we), 32'd1);
        chk("sw_wdata", dmem_wdata, 32'h1234_5678);
        chk("sw_addr",  dmem_addr, 32'h204);
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
        #1;
        chk("sw_ack_stall", 32'(oStall), 32'd0);
        cyc();
        chk("sw_rw",    32'(oRegWrite), 32'd0);
        chk("sw_valid", 32'(oValid), 32'd1);
        chk("sw_rdata", oReadData, 32'd0);
        chk("sw_memerr", 32'(oMemErr), 32'd0);

        // misaligned lw 0x102 right behind the store
        set_lw(32'h102);
        #1;
        chk("mis_stall", 32'(oStall), 32'd0);
        chk("mis_req",   32'(dmem_req), 32'd0);
        cyc();
        chk("mis_addrerr", 32'(oAddrErr), 32'd1);
        chk("mis_valid",   32'(oValid), 32'd0);
        chk("mis_wreg",    32'(owriteRegWire), 32'd0);
        chk("mis_hold_res",   oResult, 32'h204);
        chk("mis_hold_instr", oInstr, I_SW);
        chk("mis_req2",    32'(dmem_req), 32'd0);
        clr();
        cyc();
        chk("mis_pulse_once", 32'(oAddrErr), 32'd0);

        // lw with no ack: 16 request cycles, then timeout
        req_cnt = 0;
        set_lw(32'h300);
        for (int k = 0; k < 16; k++) begin
            cyc();
            req_cnt += int'(dmem_req);
        end
        chk("to_last_stall", 32'(oStall), 32'd0);
        set_add(32'd9);
        cyc();
        chk("to_req_cycles", 32'(req_cnt), 32'd16);
        chk("to_req_drop",   32'(dmem_req), 32'd0);
        chk("to_memerr",     32'(oMemErr), 32'd1);
        chk("to_bubble",     32'(oValid), 32'd0);
        cyc();
        chk("to_memerr_once", 32'(oMemErr), 32'd0);
        chk("to_add_valid",   32'(oValid), 32'd1);
        chk("to_add_result",  oResult, 32'd9);

        // ack on the last count completes normally
        set_lw(32'h400);
        for (int k = 0; k < 16; k++) begin
            cyc();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        cyc();
        chk("ack15_memerr", 32'(oMemErr), 32'd0);
        chk("ack15_valid",  32'(oValid), 32'd1);
        chk("ack15_rdata",  oReadData, 32'hCAFE_F00D);

        // ack in IDLE is ignored
        set_add(32'd11);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        cyc();
        chk("idle_ack_rdata", oReadData, 32'd0);
        chk("idle_ack_req",   32'(dmem_req), 32'd0);

        // branch resolution
        clr();
        iInstr = I_BEQ; iBranch = 1'b1; iZero = 1'b1; inextPCBranch = 32'h40;
        #1;
        chk("beq_pcsrc",  32'(oPCSrc), 32'd1);
        chk("beq_target", oBranchTarget, 32'h40);
        iZero = 1'b0;
        #1;
        chk("beq_nz_pcsrc", 32'(oPCSrc), 32'd0);
        cyc();

        // branch suppressed by stall, then reset on the 2nd WAIT cycle
        set_lw(32'h500);
        iBranch = 1'b1; iZero = 1'b1;
        #1;
        chk("stall_pcsrc", 32'(oPCSrc), 32'd0);
        cyc();
        cyc();
        chk("rw_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        clr();
        cyc();
        chk("rw_req0",   32'(dmem_req), 32'd0);
        chk("rw_valid",  32'(oValid), 32'd0);
        chk("rw_instr",  oInstr, 32'd0);
        chk("rw_result", oResult, 32'd0);
        chk("rw_rdata",  oReadData, 32'd0);
        chk("rw_addr",   dmem_addr, 32'd0);
        chk("rw_stall",  32'(oStall), 32'd0);
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        cyc();
        chk("rw_no_wb", 32'(oReadData), 32'd0);
        clr();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports exactly as below.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- iInstr  in  32  instruction from EX/MEM register
- iRegWrite, iMemRead, iMemWrite, iMemToReg, iBranch, iJump  in  1 each  EX/MEM control bits
- iB  in  32  store data
- iResult  in  32  ALU result / memory address
- iZero  in  1  ALU zero flag
- inextPCBranch  in  32  branch target
- iwriteRegWire  in  5  destination register
- oStall  out  1  hold upstream stages and EX/MEM register
- oPCSrc  out  1  branch taken
- oBranchTarget  out  32  equals inextPCBranch
- dmem_req  out  1  data memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  single-cycle completion pulse
- oInstr  out  32  MEM/WB instruction
- oRegWrite, oMemToReg  out  1 each  MEM/WB control
- oReadData  out  32  MEM/WB load data
- oResult  out  32  MEM/WB ALU result
- owriteRegWire  out  5  MEM/WB destination
- oValid  out  1  MEM/WB holds a real instruction
- oAddrErr  out  1  one-cycle pulse: misaligned access
- oMemErr  out  1  one-cycle pulse: memory timeout

Function
REQ-002 An access is present when iMemRead or iMemWrite is 1; iMemRead and iMemWrite both 1 SHALL be treated as a write.
REQ-003 The FSM SHALL have two states: IDLE and WAIT.
REQ-004 IDLE, access present, iResult[1:0]==0: latch iResult, iB, iMemWrite and all pass-through inputs; go to WAIT; MEM/WB loads a bubble.
REQ-005 IDLE, access present, iResult[1:0]!=0: no request; MEM/WB loads a bubble; oAddrErr pulses the next cycle; stay in IDLE.
REQ-006 IDLE, no access: MEM/WB loads the inputs the same edge with oReadData=0 and oValid=1 (1-cycle latency). Exception: an all-zero iInstr with iRegWrite=0 SHALL set oValid=0.
REQ-007 In WAIT: dmem_req=1, and dmem_addr, dmem_wdata and dmem_we SHALL come from the latched values, stable until ack. In IDLE: dmem_req=0.
REQ-008 WAIT with dmem_ack=1: MEM/WB loads the latched controls, oReadData=dmem_rdata (0 for writes) and oValid=1; return to IDLE.
REQ-009 WAIT with dmem_ack=0: a 4-bit wait counter increments and MEM/WB loads a bubble.
- At count 15 with no ack: drop the request, pulse oMemErr, load a bubble, return to IDLE.
- The counter clears on entering WAIT.
REQ-010 Ack arriving in the same cycle the counter reaches 15 SHALL complete normally, with no oMemErr.
REQ-011 A bubble SHALL set oRegWrite=0, oMemToReg=0, oValid=0 and owriteRegWire=0; the data fields hold their old values.
REQ-012 oStall = (IDLE and aligned access present) or (WAIT and not dmem_ack and count<15); it is combinational.
REQ-013 oPCSrc = iBranch and iZero and not oStall; it is combinational. oBranchTarget = inextPCBranch.
REQ-014 dmem_ack received in IDLE SHALL be ignored.

Reset
REQ-015 Reset SHALL force:
- state IDLE and counter 0;
- all MEM/WB outputs, oAddrErr, oMemErr and dmem_* outputs to 0.
REQ-016 Reset asserted in WAIT SHALL deassert dmem_req at that edge and discard the pending access, with no write-back.

Verification
REQ-017 Directed scenarios the bench SHALL cover:
- lw, iResult=0x100, ack 3 cycles after request, rdata=0xDEADBEEF -> oStall high 4 cycles; dmem_addr=0x100, dmem_we=0; then oReadData=0xDEADBEEF, oValid=1, oRegWrite=1 for exactly one cycle.
- sw, iResult=0x204, iB=0x12345678, ack after 1 cycle -> dmem_we=1, dmem_wdata=0x12345678; oRegWrite=0; no oMemErr.
- add, iResult=7 -> next cycle oResult=7, oValid=1, oStall never asserted.
- lw, iResult=0x102 -> dmem_req stays 0; oAddrErr pulses once; bubble written.
- lw with no ack -> dmem_req high 16 cycles; oMemErr one pulse; back to IDLE; the next add completes normally.
- beq with iZero=1, inextPCBranch=0x40 -> oPCSrc=1, oBranchTarget=0x40. Reset at the 2nd WAIT cycle -> dmem_req=0 and all outputs 0 the next cycle.
